// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory for the load/store path.
// One request in flight; sized, lane-aligned, sign/zero-extended access.
module data_mem #(
  parameter int XLEN = 64,
  parameter int DEPTH = 512,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            init_done
);

  localparam int BYTES = XLEN / 8;
  localparam int LW = $clog2(BYTES);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = LW + 3;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0] mem [DEPTH];

  logic [IW-1:0]   clr_cnt, clr_cnt_n;
  logic            done_n;
  logic [XLEN-1:0] rdata_n;
  logic            err_n;

  logic [XLEN-1:0] off;
  logic [XLEN-1:0] hi_bits;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   lane;
  logic [2:0]      lane3;
  logic [SW-1:0]   bit_sh;
  logic [3:0]      sz_oh;
  logic [2:0]      amask;

  logic below;
  logic oor;
  logic misal;
  logic bad_size;
  logic acc_err;

  logic [7:0]      be8;
  logic [BYTES-1:0] be;
  logic [XLEN-1:0] bmask;
  logic [XLEN-1:0] vmask;
  logic            sbit;

  logic [XLEN-1:0] cur;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] ext;

  logic            accept;
  logic            last_clr;
  logic            mem_we;
  logic [IW-1:0]   mem_idx;
  logic [XLEN-1:0] mem_wd;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign last_clr  = (clr_cnt == IW'(DEPTH - 1));

  // Offset wraps, so addresses below the base are caught separately.
  assign off      = req_addr - BASE_ADDR;
  assign below    = req_addr < BASE_ADDR;
  assign hi_bits  = off >> (LW + IW);
  assign oor      = |hi_bits;
  assign idx      = off[LW +: IW];
  assign lane     = off[LW-1:0];
  assign lane3    = 3'(lane);
  assign bit_sh   = {lane, 3'b000};
  assign sz_oh    = 4'b0001 << req_size;
  assign misal    = |(lane3 & amask);
  assign bad_size = sz_oh[3] && (XLEN == 32);
  assign acc_err  = below | oor | misal | bad_size;

  // Per-size alignment mask, byte enables and load value mask.
  always_comb begin
    amask = 3'd0;
    be8   = 8'h01;
    vmask = XLEN'(64'hFF);
    unique case (1'b1)
      sz_oh[0]: begin
        amask = 3'd0;
        be8   = 8'h01;
        vmask = XLEN'(64'hFF);
      end
      sz_oh[1]: begin
        amask = 3'd1;
        be8   = 8'h03;
        vmask = XLEN'(64'hFFFF);
      end
      sz_oh[2]: begin
        amask = 3'd3;
        be8   = 8'h0F;
        vmask = XLEN'(64'hFFFF_FFFF);
      end
      sz_oh[3]: begin
        amask = 3'd7;
        be8   = 8'hFF;
        vmask = '1;
      end
      default: begin
        amask = 3'd0;
        be8   = 8'h01;
        vmask = XLEN'(64'hFF);
      end
    endcase
  end

  assign be = BYTES'(be8) << lane;

  // Expand byte enables to a bit mask for the read-modify-write.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < BYTES; b++) begin
      bmask[b*8 +: 8] = {8{be[b]}};
    end
  end

  assign cur    = mem[idx];
  assign rsh    = cur >> bit_sh;
  assign wsh    = req_wdata << bit_sh;
  assign merged = (cur & ~bmask) | (wsh & bmask);

  // Pick the top bit of the extracted field for sign extension.
  always_comb begin
    sbit = rsh[7];
    unique case (1'b1)
      sz_oh[0]: sbit = rsh[7];
      sz_oh[1]: sbit = rsh[15];
      sz_oh[2]: sbit = rsh[31];
      sz_oh[3]: sbit = rsh[XLEN-1];
      default:  sbit = rsh[7];
    endcase
  end

  assign ext = (rsh & vmask) |
               ({XLEN{sbit & ~req_unsigned}} & ~vmask);

  // Next-state, array write port and response capture.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    done_n    = init_done;
    rdata_n   = rsp_rdata;
    err_n     = rsp_err;
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wd    = merged;
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt;
        mem_wd    = '0;
        clr_cnt_n = clr_cnt + 1'b1;
        if (last_clr) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_n = RESP;
          mem_we  = req_we & ~acc_err;
          err_n   = acc_err;
          rdata_n = (req_we | acc_err) ? '0 : ext;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = INIT;
      end
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Control and response registers; reset restarts the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      clr_cnt   <= clr_cnt_n;
      init_done <= done_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
    end
  end

  // Single write port shared by the clear sequencer and stores.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wd;
    end
  end

endmodule
